// File: rtl/dffram_pkg.sv
// Shared definitions for the zeroizing DFF RAM: clear-engine state
// encoding and the address-width helper used by every level.
package dffram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // 256 words per column; COLS is a power of two, so DEPTH = 2**AW.
    function automatic int unsigned addr_width(input int unsigned cols);
        return 8 + $clog2(cols);
    endfunction

endpackage

// File: rtl/dffram_clr_fsm.sv
// Zeroize engine: walks the clear counter over every word, one per cycle,
// and reports READY while user accesses may be accepted.
module dffram_clr_fsm
    import dffram_pkg::*;
#(
    parameter int AW      = 8,
    parameter bit CLR_RST = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    output logic          ready_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);

    localparam logic [AW-1:0] CNT_LAST = '1;

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          ready_q;

    // State, counter and READY advance together; READY is held in its own
    // flop so the bus side never sees a decoded glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CLR_RST ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
            ready_q <= !CLR_RST;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // A request arriving mid-clear is not seen: only IDLE samples it.
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        ready_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign clr_we_o   = (state_q == ST_CLEAR);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/dffram_zclr.sv
// Parametrised DFF RAM with byte write enables, read-before-write access,
// optional output register and a hardware zeroize engine.
module dffram_zclr
    import dffram_pkg::*;
#(
    parameter int WSIZE   = 4,
    parameter int COLS    = 1,
    parameter int OUT_REG = 0,
    parameter int CLR_RST = 1,
    localparam int DW     = 8 * WSIZE,
    localparam int AW     = addr_width(COLS),
    localparam int DEPTH  = 256 * COLS
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             EN,
    input  logic [WSIZE-1:0] WE,
    input  logic [AW-1:0]    A,
    input  logic [DW-1:0]    Di,
    output logic [DW-1:0]    Do,
    output logic             VALID,
    input  logic             CLR,
    output logic             READY
);

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          acc;

    logic [WSIZE-1:0] wr_be;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;

    logic [DW-1:0] mem_q [DEPTH];

    logic [DW-1:0] s1_data_q;
    logic          s1_valid_q;

    dffram_clr_fsm #(
        .AW      (AW),
        .CLR_RST (CLR_RST != 0)
    ) u_clr_fsm (
        .clk_i      (CLK),
        .rst_ni     (RESETn),
        .clr_i      (CLR),
        .ready_o    (READY),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // User accesses are only taken while the clear engine is idle.
    assign acc = EN && READY;

    // Write-port mux: the clear engine owns the port during CLEAR.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an uncovered path holds its old value and infers a latch.
        wr_be   = '0;
        wr_addr = A;
        wr_data = Di;
        if (clr_we) begin
            wr_be   = '1;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (acc) begin
            wr_be = WE;
        end
    end

    // Byte-masked array write.
    // NOTE: the storage array deliberately has no reset; clearing it is the
    // zeroize engine's job, and a reset would turn every word into flops with
    // reset fan-out.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < WSIZE; i++) begin
            if (wr_be[i]) begin
                mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Stage 1 captures the pre-write word (read-before-write), or zero when idle.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so that this
            // read of mem_q sees the value from before the same-edge write.
            s1_valid_q <= acc;
            s1_data_q  <= acc ? mem_q[A] : '0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] s2_data_q;
            logic          s2_valid_q;

            // Optional second stage: passes the data/valid pair along unchanged.
            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_data_q  <= s1_data_q;
                    s2_valid_q <= s1_valid_q;
                end
            end

            assign Do    = s2_data_q;
            assign VALID = s2_valid_q;
        end else begin : g_no_out_reg
            assign Do    = s1_data_q;
            assign VALID = s1_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_dffram_zclr.sv
// Self-checking bench: dut0 uses the default configuration, dut1 the wide
// (COLS=4, WSIZE=2, OUT_REG=1) one. Reads are scored against a queue of
// expected words with their due cycle, filled from a bench-side memory model.
module tb_dffram_zclr;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic CLK = 1'b0;
    logic RESETn;

    logic        en0, clr0, valid0, ready0;
    logic [3:0]  we0;
    logic [7:0]  a0;
    logic [31:0] di0, do0;

    logic        en1, clr1, valid1, ready1;
    logic [1:0]  we1;
    logic [9:0]  a1;
    logic [15:0] di1, do1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    logic [31:0] m0 [256];
    logic [15:0] m1 [1024];

    int n;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    dffram_zclr u_dut0 (
        .CLK (CLK), .RESETn (RESETn), .EN (en0), .WE (we0), .A (a0), .Di (di0),
        .Do (do0), .VALID (valid0), .CLR (clr0), .READY (ready0)
    );

    dffram_zclr #(.WSIZE(2), .COLS(4), .OUT_REG(1), .CLR_RST(1)) u_dut1 (
        .CLK (CLK), .RESETn (RESETn), .EN (en1), .WE (we1), .A (a1), .Di (di1),
        .Do (do1), .VALID (valid1), .CLR (clr1), .READY (ready1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard for dut0: every cycle either pops a due read or demands Do=0.
    always @(negedge CLK) begin
        if (RESETn) begin
            if (valid0) begin
                if (q0.size() == 0) begin
                    check("dut0 VALID without pending read", valid0, 0);
                end else begin
                    e0 = q0.pop_front();
                    check("dut0 Do", do0, e0.data);
                    check("dut0 latency", cyc, e0.due);
                end
            end else begin
                check("dut0 Do zero when not VALID", do0, 0);
                if (q0.size() != 0 && q0[0].due < cyc) begin
                    void'(q0.pop_front());
                    check("dut0 VALID missing", valid0, 1);
                end
            end
        end
    end

    // Scoreboard for dut1.
    always @(negedge CLK) begin
        if (RESETn) begin
            if (valid1) begin
                if (q1.size() == 0) begin
                    check("dut1 VALID without pending read", valid1, 0);
                end else begin
                    e1 = q1.pop_front();
                    check("dut1 Do", do1, e1.data);
                    check("dut1 latency", cyc, e1.due);
                end
            end else begin
                check("dut1 Do zero when not VALID", do1, 0);
                if (q1.size() != 0 && q1[0].due < cyc) begin
                    void'(q1.pop_front());
                    check("dut1 VALID missing", valid1, 1);
                end
            end
        end
    end

    // One-cycle access on dut0, driven at a negedge; returns at the next negedge.
    task automatic access0(input logic [7:0] a, input logic [3:0] we,
                           input logic [31:0] d, input logic clr);
        exp_t e;
        en0 = 1'b1; a0 = a; we0 = we; di0 = d; clr0 = clr;
        if (ready0) begin
            e.data = m0[a];
            e.due  = cyc + 1;
            q0.push_back(e);
            for (int i = 0; i < 4; i++) if (we[i]) m0[a][8*i +: 8] = d[8*i +: 8];
        end
        @(negedge CLK);
        en0 = 1'b0; we0 = '0; clr0 = 1'b0;
    endtask

    task automatic access1(input logic [9:0] a, input logic [1:0] we, input logic [15:0] d);
        exp_t e;
        en1 = 1'b1; a1 = a; we1 = we; di1 = d;
        if (ready1) begin
            e.data = {16'h0, m1[a]};
            e.due  = cyc + 2;
            q1.push_back(e);
            for (int i = 0; i < 2; i++) if (we[i]) m1[a][8*i +: 8] = d[8*i +: 8];
        end
        @(negedge CLK);
        en1 = 1'b0; we1 = '0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge CLK);
    endtask

    // Counts cycles with READY=0 on dut0, starting at the negedge where the
    // clear is pending. Optionally hammers CLR and a full write meanwhile.
    task automatic measure0(input bit pulse, output int cnt);
        cnt = 0;
        while (!ready0 && cnt < 3000) begin
            if (pulse && cnt >= 50 && cnt < 60) begin
                clr0 = 1'b1; en0 = 1'b1; we0 = '1; a0 = 8'h33; di0 = '1;
            end else begin
                clr0 = 1'b0; en0 = 1'b0; we0 = '0;
            end
            cnt++;
            @(negedge CLK);
        end
        clr0 = 1'b0; en0 = 1'b0; we0 = '0;
        for (int i = 0; i < 256; i++) m0[i] = '0;
    endtask

    task automatic check_reset_state();
        check("reset dut0 Do", do0, 0);
        check("reset dut0 VALID", valid0, 0);
        check("reset dut0 READY", ready0, 0);
        check("reset dut1 Do", do1, 0);
        check("reset dut1 VALID", valid1, 0);
        check("reset dut1 READY", ready1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETn = 1'b0;
        en0 = 0; we0 = 0; a0 = 0; di0 = 0; clr0 = 0;
        en1 = 0; we1 = 0; a1 = 0; di1 = 0; clr1 = 0;
        for (int i = 0; i < 1024; i++) m1[i] = '0;

        // Reset state, then automatic zeroize of 256 cycles.
        idle(3);
        check_reset_state();
        RESETn = 1'b1;
        measure0(1'b0, n);
        check("clear length after reset", n, 256);
        access0(8'h00, 4'h0, 32'h0, 1'b0);
        access0(8'h7F, 4'h0, 32'h0, 1'b0);
        access0(8'hFF, 4'h0, 32'h0, 1'b0);
        idle(3);

        // Full-word write then a single-byte merge.
        access0(8'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        access0(8'h10, 4'b0100, 32'h00AA0000, 1'b0);
        access0(8'h10, 4'h0, 32'h0, 1'b0);
        idle(3);
        check("merged word model", m0[8'h10], 32'hDEAABEEF);

        // Read-before-write returns the old word; idle cycles in between.
        access0(8'h20, 4'hF, 32'h1, 1'b0);
        idle(2);
        access0(8'h20, 4'h0, 32'h0, 1'b0);
        idle(3);

        // CLR with a concurrent read; CLR pulses and writes during CLEAR ignored.
        access0(8'h10, 4'h0, 32'h0, 1'b1);
        measure0(1'b1, n);
        check("clear length after CLR", n, 256);
        access0(8'h10, 4'h0, 32'h0, 1'b0);
        access0(8'h33, 4'h0, 32'h0, 1'b0);
        idle(3);

        // Reset in the middle of CLEAR restarts a full clear.
        access0(8'h05, 4'hF, 32'h12345678, 1'b0);
        access0(8'hF0, 4'hF, 32'hCAFEF00D, 1'b0);
        access0(8'h00, 4'h0, 32'h0, 1'b1);
        idle(100);
        RESETn = 1'b0;
        @(negedge CLK);
        check_reset_state();
        RESETn = 1'b1;
        for (int i = 0; i < 1024; i++) m1[i] = '0;
        measure0(1'b1, n);
        check("clear length after reset mid-clear", n, 256);
        access0(8'h05, 4'h0, 32'h0, 1'b0);
        access0(8'hF0, 4'h0, 32'h0, 1'b0);
        access0(8'hFF, 4'h0, 32'h0, 1'b0);
        idle(3);

        // Wide configuration: 1024-cycle clear, 16-bit data, latency 2.
        RESETn = 1'b0;
        @(negedge CLK);
        RESETn = 1'b1;
        for (int i = 0; i < 1024; i++) m1[i] = '0;
        n = 0;
        while (!ready1 && n < 5000) begin
            n++;
            @(negedge CLK);
        end
        check("dut1 clear length", n, 1024);
        access1(10'h3FF, 2'b11, 16'hA5C3);
        access1(10'h3FF, 2'b01, 16'h0011);
        access1(10'h3FF, 2'b00, 16'h0000);
        access1(10'h000, 2'b00, 16'h0000);
        idle(5);
        check("dut1 merged word model", m1[10'h3FF], 32'h0000A511);

        check("dut0 scoreboard drained", q0.size(), 0);
        check("dut1 scoreboard drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
